rider_detect: RTL and testbench



---
 rtl/rider_detect.sv | 95 +++++++++
 tb/tb_rider_detect.sv | 119 +++++++++++
 2 files changed

// File: rtl/rider_detect.sv
// rtl/rider_detect.sv - rider presence and steering-enable qualifier
// Weight threshold with hysteresis, balance checks and a settle timer gate en_steer.
module rider_detect #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter logic [26:0] SETTLE_CNT   = 27'd67_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        vld,
    output logic        rider_off,
    output logic        en_steer
);

    typedef enum logic [1:0] {
        S_NORIDER  = 2'b00,
        S_WAIT     = 2'b01,
        S_STEER_EN = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] lft_q, rght_q;
    logic [26:0] cnt_q, cnt_d;

    logic [16:0] sum, diff, on_thr, off_thr;
    logic        present_hi, present_lo, imbal_small, imbal_large, tmr_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    // Everything is widened to 17 bits so the scaled compares cannot wrap.
    always_comb begin
        sum         = 17'(lft_q) + 17'(rght_q);
        diff        = (lft_q >= rght_q) ? 17'(lft_q - rght_q) : 17'(rght_q - lft_q);
        on_thr      = 17'(MIN_RIDER_WT) + 17'(WT_HYST);
        off_thr     = 17'(MIN_RIDER_WT) - 17'(WT_HYST);
        present_hi  = sum > on_thr;
        present_lo  = sum < off_thr;
        imbal_small = (diff << 2) > sum;
        imbal_large = (diff << 4) > (sum * 17'd15);
    end

    assign tmr_full = (cnt_q == SETTLE_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NORIDER;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The timer only runs in WAIT; holding it at zero elsewhere clears it on every entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_NORIDER: begin
                if (present_hi) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (present_lo) begin
                    state_d = S_NORIDER;
                end else if (imbal_small) begin
                    cnt_d = '0;
                end else if (tmr_full) begin
                    state_d = S_STEER_EN;
                    cnt_d   = cnt_q;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            S_STEER_EN: begin
                if (present_lo)       state_d = S_NORIDER;
                else if (imbal_large) state_d = S_WAIT;
            end
            default: state_d = S_NORIDER;
        endcase
    end

    assign rider_off = (state_q == S_NORIDER);
    assign en_steer  = (state_q == S_STEER_EN);

endmodule

// File: tb/tb_rider_detect.sv
// tb/tb_rider_detect.sv - directed scoreboard bench for rider_detect
module tb_rider_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        vld = 1'b0;
    logic        rider_off, en_steer;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string    tag;
        logic [1:0] outs;
    } exp_t;

    exp_t sb_q[$];

    rider_detect #(
        .MIN_RIDER_WT(12'h200),
        .WT_HYST(12'h040),
        .SETTLE_CNT(27'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lft_ld(lft_ld),
        .rght_ld(rght_ld),
        .vld(vld),
        .rider_off(rider_off),
        .en_steer(en_steer)
    );

    always #5 clk = ~clk;

    // Drive one cycle, queue the expected {rider_off,en_steer} after the edge, then check it.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [11:0] l, input logic [11:0] rr,
                        input logic exp_off, input logic exp_en);
        exp_t e;
        exp_t got;
        rst     = r;
        vld     = v;
        lft_ld  = l;
        rght_ld = rr;
        e.tag  = tag;
        e.outs = {exp_off, exp_en};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        tests_run++;
        assert ({rider_off, en_steer} === got.outs)
        else begin
            tests_failed++;
            $error("FAIL %s: {rider_off,en_steer} observed %b expected %b",
                   got.tag, {rider_off, en_steer}, got.outs);
        end
    endtask

    task automatic idle(input string tag, input int n, input logic exp_off, input logic exp_en);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 12'h000, 12'h000, exp_off, exp_en);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            step("reset_hold", 1'b1, 1'($urandom_range(0, 1)),
                 12'($urandom), 12'($urandom), 1'b1, 1'b0);
        step("reset_release", 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0);

        step("entry_capture", 1'b0, 1'b1, 12'h150, 12'h150, 1'b1, 1'b0);
        step("entry_wait", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        idle("settle_wait", 16, 1'b0, 1'b0);
        step("settle_steer", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);

        step("hyst_steer_cap", 1'b0, 1'b1, 12'h118, 12'h118, 1'b0, 1'b1);
        idle("hyst_steer_hold", 4, 1'b0, 1'b1);
        step("drop_cap", 1'b0, 1'b1, 12'h0D8, 12'h0D8, 1'b0, 1'b1);
        step("drop_norider", 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0);
        step("hyst_norider_cap", 1'b0, 1'b1, 12'h118, 12'h118, 1'b1, 1'b0);
        idle("hyst_norider_hold", 4, 1'b1, 1'b0);

        step("hold_cap", 1'b0, 1'b1, 12'h200, 12'h080, 1'b1, 1'b0);
        step("hold_wait", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        idle("hold_imbal", 100, 1'b0, 1'b0);
        step("hold_rebal_cap", 1'b0, 1'b1, 12'h140, 12'h140, 1'b0, 1'b0);
        idle("hold_rebal_wait", 16, 1'b0, 1'b0);
        step("hold_rebal_steer", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);

        step("mod_imbal_cap", 1'b0, 1'b1, 12'h200, 12'h080, 1'b0, 1'b1);
        idle("mod_imbal_hold", 5, 1'b0, 1'b1);
        step("large_imbal_cap", 1'b0, 1'b1, 12'h3F0, 12'h008, 1'b0, 1'b1);
        step("large_imbal_wait", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 0);
        idle("large_imbal_hold", 3, 1'b0, 1'b0);
        step("rebal_cap", 1'b0, 1'b1, 12'h140, 12'h140, 1'b0, 1'b0);
        idle("rebal_wait", 16, 1'b0, 1'b0);
        step("rebal_steer", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);

        step("leave_cap", 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 1'b1);
        step("leave_norider", 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0);
        step("rewait_cap", 1'b0, 1'b1, 12'h150, 12'h150, 1'b1, 1'b0);
        step("rewait_enter", 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        idle("rewait_count", 10, 1'b0, 1'b0);
        step("rst_vld_coincide", 1'b1, 1'b1, 12'h300, 12'h300, 1'b1, 1'b0);
        idle("post_rst_no_capture", 4, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
